// File: rtl/chess_clock_pkg.sv
// Shared types and constants for the two-player chess clock.
package chess_clock_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    FLAGGED
  } state_t;

  typedef struct packed {
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [2:0] sec_tens;
    logic [3:0] sec_ones;
  } bcd_time_t;

  localparam bcd_time_t MAX_TIME  = '{min_tens: 4'd9, min_ones: 4'd9, sec_tens: 3'd5, sec_ones: 4'd9};
  localparam bcd_time_t ZERO_TIME = '0;

  function automatic bcd_time_t to_bcd(input int unsigned mins, input int unsigned secs);
    bcd_time_t t;
    t.min_tens = 4'(mins / 10);
    t.min_ones = 4'(mins % 10);
    t.sec_tens = 3'(secs / 10);
    t.sec_ones = 4'(secs % 10);
    return t;
  endfunction

endpackage

// File: rtl/chess_time_counter.sv
// One player's BCD MM:SS register: reload, 1 s decrement with borrow, and
// saturating increment. zero flags that this cycle's decrement lands on 00:00.
module chess_time_counter
  import chess_clock_pkg::*;
#(
  parameter int unsigned INIT_MIN = 5,
  parameter int unsigned INIT_SEC = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic       dec,
  input  logic       inc_en,
  input  logic [5:0] inc_sec,
  output bcd_time_t  value,
  output logic       zero
);

  localparam bcd_time_t INIT_TIME = to_bcd(INIT_MIN, INIT_SEC);

  bcd_time_t  value_q, value_d;
  bcd_time_t  dec_val, base_val, inc_val;
  logic [6:0] sec_sum;
  logic [5:0] sec_wrap;
  logic       sec_carry;

  always_comb begin
    dec_val = value_q;
    if (value_q != ZERO_TIME) begin
      if (value_q.sec_ones != 4'd0) begin
        dec_val.sec_ones = value_q.sec_ones - 4'd1;
      end else begin
        dec_val.sec_ones = 4'd9;
        if (value_q.sec_tens != 3'd0) begin
          dec_val.sec_tens = value_q.sec_tens - 3'd1;
        end else begin
          dec_val.sec_tens = 3'd5;
          if (value_q.min_ones != 4'd0) begin
            dec_val.min_ones = value_q.min_ones - 4'd1;
          end else begin
            dec_val.min_ones = 4'd9;
            dec_val.min_tens = value_q.min_tens - 4'd1;
          end
        end
      end
    end
  end

  assign base_val = dec ? dec_val : value_q;
  assign zero     = dec && (dec_val == ZERO_TIME);

  // Seconds are added in binary (at most 59+59) and split back into BCD digits.
  always_comb begin
    sec_sum   = 7'(base_val.sec_tens) * 7'd10 + 7'(base_val.sec_ones) + 7'(inc_sec);
    sec_carry = (sec_sum >= 7'd60);
    sec_wrap  = sec_carry ? 6'(sec_sum - 7'd60) : 6'(sec_sum);
    inc_val          = base_val;
    inc_val.sec_tens = 3'(sec_wrap / 6'd10);
    inc_val.sec_ones = 4'(sec_wrap % 6'd10);
    if (sec_carry) begin
      if (base_val.min_ones != 4'd9) begin
        inc_val.min_ones = base_val.min_ones + 4'd1;
      end else if (base_val.min_tens != 4'd9) begin
        inc_val.min_ones = 4'd0;
        inc_val.min_tens = base_val.min_tens + 4'd1;
      end else begin
        inc_val = MAX_TIME;
      end
    end
  end

  always_comb begin
    value_d = base_val;
    if (load) begin
      value_d = INIT_TIME;
    end else if (inc_en) begin
      value_d = inc_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= INIT_TIME;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/chess_clock_ctrl.sv
// Chess clock control: game FSM, 1 Hz prescaler, side-to-move register and
// sticky flags around two chess_time_counter instances.
module chess_clock_ctrl
  import chess_clock_pkg::*;
#(
  parameter int unsigned CLK_HZ   = 100_000_000,
  parameter int unsigned INIT_MIN = 5,
  parameter int unsigned INIT_SEC = 0,
  parameter int unsigned INC_SEC  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        start,
  input  logic        pause,
  input  logic        move_done,
  output logic        side,
  output logic [14:0] time_white,
  output logic [14:0] time_black,
  output logic        flag_white,
  output logic        flag_black,
  output logic        running
);

  localparam int unsigned  PW        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [5:0]   INC_VAL   = 6'(INC_SEC);

  state_t        state_q, state_d;
  logic          side_q, side_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          flag_white_q, flag_white_d;
  logic          flag_black_q, flag_black_d;
  logic          running_q, running_d;

  bcd_time_t white_val, black_val;
  logic      white_zero, black_zero;
  logic      tick, flag_hit, accept;
  logic      dec_w, dec_b, inc_w, inc_b;

  assign tick     = (state_q == RUN) && (presc_q == PRESC_MAX);
  assign dec_w    = tick && !side_q;
  assign dec_b    = tick && side_q;
  assign flag_hit = side_q ? black_zero : white_zero;
  // A move landing on the tick that empties the mover's clock loses to the flag.
  assign accept   = (state_q == RUN) && move_done && !flag_hit && !new_game;
  assign inc_w    = accept && !side_q;
  assign inc_b    = accept && side_q;

  chess_time_counter #(.INIT_MIN(INIT_MIN), .INIT_SEC(INIT_SEC)) u_white (
    .clk(clk), .rst(rst), .load(new_game), .dec(dec_w), .inc_en(inc_w),
    .inc_sec(INC_VAL), .value(white_val), .zero(white_zero)
  );

  chess_time_counter #(.INIT_MIN(INIT_MIN), .INIT_SEC(INIT_SEC)) u_black (
    .clk(clk), .rst(rst), .load(new_game), .dec(dec_b), .inc_en(inc_b),
    .inc_sec(INC_VAL), .value(black_val), .zero(black_zero)
  );

  always_comb begin
    state_d      = state_q;
    side_d       = side_q;
    presc_d      = presc_q;
    flag_white_d = flag_white_q;
    flag_black_d = flag_black_q;
    if (new_game) begin
      state_d      = IDLE;
      side_d       = 1'b0;
      presc_d      = '0;
      flag_white_d = 1'b0;
      flag_black_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) state_d = RUN;
        end
        RUN: begin
          presc_d = tick ? '0 : presc_q + PW'(1);
          if (flag_hit) begin
            state_d = FLAGGED;
            if (side_q) flag_black_d = 1'b1;
            else        flag_white_d = 1'b1;
          end else begin
            if (accept) begin
              side_d  = !side_q;
              presc_d = '0;
            end
            if (pause) state_d = PAUSED;
          end
        end
        PAUSED: begin
          if (!pause) state_d = RUN;
        end
        FLAGGED: ;
        default: state_d = IDLE;
      endcase
    end
    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      side_q       <= 1'b0;
      presc_q      <= '0;
      flag_white_q <= 1'b0;
      flag_black_q <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      side_q       <= side_d;
      presc_q      <= presc_d;
      flag_white_q <= flag_white_d;
      flag_black_q <= flag_black_d;
      running_q    <= running_d;
    end
  end

  assign side       = side_q;
  assign time_white = white_val;
  assign time_black = black_val;
  assign flag_white = flag_white_q;
  assign flag_black = flag_black_q;
  assign running    = running_q;

endmodule

// File: tb/tb_chess_clock_ctrl.sv
// Drives three chess clocks (00:03+2, 99:58+5, 10:00+0) with shared stimulus and
// compares every cycle against a model that keeps time as plain seconds.
module tb_chess_clock_ctrl;

  localparam int CLK_HZ = 4;
  localparam int N      = 3;
  localparam int INIT_S [N] = '{3, 99 * 60 + 58, 600};
  localparam int INC_S  [N] = '{2, 5, 0};

  logic        clk = 1'b0;
  logic        rst, new_game, start, pause, move_done;
  logic        side_o [N];
  logic [14:0] tw_o   [N];
  logic [14:0] tb_o   [N];
  logic        fw_o   [N];
  logic        fb_o   [N];
  logic        run_o  [N];

  int m_tw [N], m_tb [N], m_side [N], m_presc [N], m_st [N], m_fw [N], m_fb [N];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chess_clock_ctrl #(.CLK_HZ(CLK_HZ), .INIT_MIN(0), .INIT_SEC(3), .INC_SEC(2)) u_a (
    .clk(clk), .rst(rst), .new_game(new_game), .start(start), .pause(pause),
    .move_done(move_done), .side(side_o[0]), .time_white(tw_o[0]), .time_black(tb_o[0]),
    .flag_white(fw_o[0]), .flag_black(fb_o[0]), .running(run_o[0])
  );
  chess_clock_ctrl #(.CLK_HZ(CLK_HZ), .INIT_MIN(99), .INIT_SEC(58), .INC_SEC(5)) u_b (
    .clk(clk), .rst(rst), .new_game(new_game), .start(start), .pause(pause),
    .move_done(move_done), .side(side_o[1]), .time_white(tw_o[1]), .time_black(tb_o[1]),
    .flag_white(fw_o[1]), .flag_black(fb_o[1]), .running(run_o[1])
  );
  chess_clock_ctrl #(.CLK_HZ(CLK_HZ), .INIT_MIN(10), .INIT_SEC(0), .INC_SEC(0)) u_c (
    .clk(clk), .rst(rst), .new_game(new_game), .start(start), .pause(pause),
    .move_done(move_done), .side(side_o[2]), .time_white(tw_o[2]), .time_black(tb_o[2]),
    .flag_white(fw_o[2]), .flag_black(fb_o[2]), .running(run_o[2])
  );

  function automatic logic [14:0] bcd(input int s);
    int m, sc;
    m  = s / 60;
    sc = s % 60;
    return {4'(m / 10), 4'(m % 10), 3'(sc / 10), 4'(sc % 10)};
  endfunction

  task automatic chk(input string name, input int k, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s[%0d] got=%0d want=%0d at %0t", name, k, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_tw[k] = INIT_S[k]; m_tb[k] = INIT_S[k];
      m_side[k] = 0; m_presc[k] = 0; m_st[k] = 0; m_fw[k] = 0; m_fb[k] = 0;
    end
  endtask

  // States: 0 idle, 1 run, 2 paused, 3 flagged.
  task automatic model_step();
    int tick, flagged;
    for (int k = 0; k < N; k++) begin
      if (new_game) begin
        m_tw[k] = INIT_S[k]; m_tb[k] = INIT_S[k];
        m_side[k] = 0; m_presc[k] = 0; m_st[k] = 0; m_fw[k] = 0; m_fb[k] = 0;
      end else if (m_st[k] == 0) begin
        if (start) m_st[k] = 1;
      end else if (m_st[k] == 1) begin
        tick    = (m_presc[k] == CLK_HZ - 1) ? 1 : 0;
        flagged = 0;
        m_presc[k] = tick ? 0 : m_presc[k] + 1;
        if (tick && m_side[k] == 0) begin
          m_tw[k]--;
          if (m_tw[k] == 0) begin m_fw[k] = 1; flagged = 1; end
        end else if (tick) begin
          m_tb[k]--;
          if (m_tb[k] == 0) begin m_fb[k] = 1; flagged = 1; end
        end
        if (flagged) begin
          m_st[k] = 3;
        end else begin
          if (move_done) begin
            if (m_side[k] == 0) m_tw[k] = (m_tw[k] + INC_S[k] > 5999) ? 5999 : m_tw[k] + INC_S[k];
            else                m_tb[k] = (m_tb[k] + INC_S[k] > 5999) ? 5999 : m_tb[k] + INC_S[k];
            m_side[k]  = 1 - m_side[k];
            m_presc[k] = 0;
          end
          if (pause) m_st[k] = 2;
        end
      end else if (m_st[k] == 2) begin
        if (!pause) m_st[k] = 1;
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < N; k++) begin
      chk("side",       k, int'(side_o[k]), m_side[k]);
      chk("time_white", k, int'(tw_o[k]),   int'(bcd(m_tw[k])));
      chk("time_black", k, int'(tb_o[k]),   int'(bcd(m_tb[k])));
      chk("flag_white", k, int'(fw_o[k]),   m_fw[k]);
      chk("flag_black", k, int'(fb_o[k]),   m_fb[k]);
      chk("running",    k, int'(run_o[k]),  (m_st[k] == 1) ? 1 : 0);
    end
  endtask

  task automatic step(input logic ng, input logic st, input logic pa, input logic md);
    new_game = ng; start = st; pause = pa; move_done = md;
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic run_n(input int n, input logic pa);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, pa, 1'b0);
  endtask

  // Called just after a clock edge; outputs must reload before the next edge.
  task automatic async_rst();
    rst = 1'b1;
    #2;
    model_reset();
    check_all();
    chk("async_white_lit", 0, int'(tw_o[0]), 3);
    chk("async_run_lit",   0, int'(run_o[0]), 0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    logic pa_lvl;
    rst = 1'b1; new_game = 1'b0; start = 1'b0; pause = 1'b0; move_done = 1'b0;
    model_reset();
    #12;
    check_all();
    chk("reset_white_lit", 0, int'(tw_o[0]), 3);
    rst = 1'b0;

    // Free run: white flags on its third tick.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_n(4, 1'b0);
    chk("w_tick1_lit",  0, int'(tw_o[0]), 2);
    chk("borrow_lit",   2, int'(tw_o[2]), 1241);
    run_n(8, 1'b0);
    chk("w_zero_lit",   0, int'(tw_o[0]), 0);
    chk("w_flag_lit",   0, int'(fw_o[0]), 1);
    chk("black_lit",    0, int'(tb_o[0]), 3);

    // Move with increment, then black's first tick.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_n(4, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("w_inc_lit",    0, int'(tw_o[0]), 4);
    chk("side_lit",     0, int'(side_o[0]), 1);
    chk("sat_lit",      1, int'(tw_o[1]), 19673);
    run_n(4, 1'b0);
    chk("b_tick_lit",   0, int'(tb_o[0]), 2);

    // Pause mid-second.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_n(2, 1'b0);
    run_n(20, 1'b1);
    chk("paused_lit",   0, int'(tw_o[0]), 3);
    run_n(2, 1'b0);
    chk("resume_lit",   0, int'(tw_o[0]), 2);

    // Move on the tick that empties white's clock.
    step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_n(11, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    chk("tie_white_lit", 0, int'(tw_o[0]), 0);
    chk("tie_flag_lit",  0, int'(fw_o[0]), 1);
    chk("tie_side_lit",  0, int'(side_o[0]), 0);

    // Flagged ignores move_done and start; new_game reloads.
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    chk("ng_white_lit", 0, int'(tw_o[0]), 3);
    chk("ng_flag_lit",  0, int'(fw_o[0]), 0);

    // Asynchronous reset mid-run.
    step(1'b0, 1'b1, 1'b0, 1'b0);
    run_n(5, 1'b0);
    async_rst();

    // Random traffic.
    pa_lvl = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) pa_lvl = ~pa_lvl;
      step(($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 15), pa_lvl,
           ($urandom_range(0, 99) < 12));
      if ($urandom_range(0, 499) == 0) async_rst();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
